// File: rtl/food_map_ctrl_if.sv
// Renderer / maze-ROM / game-logic signal bundle for the food map controller.
// The controller owns the slave end; the game top (or bench) owns the master end.
interface food_map_ctrl_if #(
    parameter int COLS = 80
);
    logic [5:0]      food_idx_y;
    logic [COLS-1:0] food_row;
    logic [5:0]      map_addr;
    logic [COLS-1:0] map_row;
    logic            refill_start;
    logic            pos_valid;
    logic [10:0]     pacman_blkpos_x;
    logic [9:0]      pacman_blkpos_y;
    logic            eat_pulse;
    logic [15:0]     score;
    logic [12:0]     food_left;
    logic            all_eaten;
    logic            busy;

    modport slave (
        input  food_idx_y, map_row, refill_start, pos_valid, pacman_blkpos_x, pacman_blkpos_y,
        output food_row, map_addr, eat_pulse, score, food_left, all_eaten, busy
    );

    modport master (
        output food_idx_y, map_row, refill_start, pos_valid, pacman_blkpos_x, pacman_blkpos_y,
        input  food_row, map_addr, eat_pulse, score, food_left, all_eaten, busy
    );
endinterface

// File: rtl/food_map_ctrl.sv
// Pellet map owner: refills from the maze ROM, clears pellets under Pac-Man,
// keeps the BCD score / remaining count, and serves rows to the renderer.
module food_map_ctrl #(
    parameter int ROWS       = 50,
    parameter int COLS       = 80,
    parameter int BLK_SHIFT  = 4,
    parameter int CENTER_OFS = 8
) (
    input  logic         clk,
    input  logic         rst,
    food_map_ctrl_if.slave bus
);
    localparam int CW = $clog2(COLS);

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_CHECK, S_CLEAR} state_t;

    state_t          r_state, w_next;
    logic [5:0]      r_cnt;
    logic [CW-1:0]   r_col;
    logic [5:0]      r_row;
    logic [COLS-1:0] r_map [ROWS];
    logic [COLS-1:0] r_food_row;
    logic            r_eat;
    logic [15:0]     r_score;
    logic [12:0]     r_food_left;

    logic [11:0]     w_col;
    logic [10:0]     w_row;
    logic            w_in_range;
    logic            w_hit;
    logic            w_eat;
    logic            w_refill_wr;
    logic            w_enter_refill;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int d = 0; d < 4; d++) begin
                if (c) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Widened sums so the centre offset can never overflow into a wrong cell.
    assign w_col          = ({1'b0, bus.pacman_blkpos_x} + 12'(CENTER_OFS)) >> BLK_SHIFT;
    assign w_row          = ({1'b0, bus.pacman_blkpos_y} + 11'(CENTER_OFS)) >> BLK_SHIFT;
    assign w_in_range     = (w_col < 12'(COLS)) && (w_row < 11'(ROWS));
    assign w_hit          = r_map[r_row][r_col];
    assign w_eat          = (r_state == S_CLEAR) && !bus.refill_start;
    assign w_refill_wr    = (r_state == S_REFILL) && (r_cnt != 6'd0);
    assign w_enter_refill = (r_state != S_REFILL) && bus.refill_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_REFILL: if (r_cnt == 6'(ROWS)) w_next = S_IDLE;
            S_IDLE: begin
                if (bus.refill_start)                  w_next = S_REFILL;
                else if (bus.pos_valid && w_in_range)  w_next = S_CHECK;
            end
            S_CHECK: begin
                if (bus.refill_start) w_next = S_REFILL;
                else if (w_hit)       w_next = S_CLEAR;
                else                  w_next = S_IDLE;
            end
            S_CLEAR: w_next = bus.refill_start ? S_REFILL : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REFILL;
            r_cnt   <= 6'd0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter_refill)
                r_cnt <= 6'd0;
            else if (r_state == S_REFILL)
                r_cnt <= r_cnt + 6'd1;
            if (r_state == S_IDLE && bus.pos_valid && w_in_range) begin
                r_col <= w_col[CW-1:0];
                r_row <= w_row[5:0];
            end
        end
    end

    // ROM data lags the address by one cycle, so row cnt-1 lands when the counter reads cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) r_map[i] <= '0;
        end else if (w_refill_wr) begin
            r_map[r_cnt - 6'd1] <= bus.map_row;
        end else if (w_eat) begin
            r_map[r_row][r_col] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_food_row  <= '0;
            r_eat       <= 1'b0;
            r_score     <= 16'h0000;
            r_food_left <= '0;
        end else begin
            r_food_row <= (bus.food_idx_y < 6'(ROWS)) ? r_map[bus.food_idx_y] : '0;
            r_eat      <= w_eat;
            if (w_eat)
                r_score <= bcd_inc(r_score);
            if (w_enter_refill)
                r_food_left <= '0;
            else if (w_refill_wr)
                r_food_left <= r_food_left + 13'($countones(bus.map_row));
            else if (w_eat && r_food_left != '0)
                r_food_left <= r_food_left - 13'd1;
        end
    end

    assign bus.food_row  = r_food_row;
    assign bus.map_addr  = r_cnt;
    assign bus.eat_pulse = r_eat;
    assign bus.score     = r_score;
    assign bus.food_left = r_food_left;
    assign bus.all_eaten = (r_state == S_IDLE) && (r_food_left == '0);
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_food_map_ctrl.sv
// Randomized scoreboard bench for food_map_ctrl: a cell-level model predicts each
// eat, and a monitor pops the prediction whenever the DUT pulses eat_pulse.
module tb_food_map_ctrl;
    localparam int ROWS = 50;
    localparam int COLS = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;

    food_map_ctrl_if #(.COLS(COLS)) bus();

    food_map_ctrl #(.ROWS(ROWS), .COLS(COLS), .BLK_SHIFT(4), .CENTER_OFS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [COLS-1:0] rom [ROWS];
    logic [COLS-1:0] mdl [ROWS];
    int sc = 0;
    int fl = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] score;
        int          fl;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always @(posedge clk) bus.map_row <= (bus.map_addr < ROWS) ? rom[bus.map_addr] : '0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.eat_pulse) begin
            exp_t e;
            if (q.size() == 0) begin
                chk("unexpected_eat", 1, 0);
            end else begin
                e = q.pop_front();
                chk("eat_score", bus.score, e.score);
                chk("eat_food_left", bus.food_left, e.fl);
                chk("eat_latency", cyc - e.cyc, 2);
            end
        end
    end

    task automatic load_model();
        fl = 0;
        for (int r = 0; r < ROWS; r++) begin
            mdl[r] = rom[r];
            fl += $countones(rom[r]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic refill();
        bus.refill_start = 1'b1;
        @(negedge clk);
        bus.refill_start = 1'b0;
        chk("refill_busy", bus.busy, 1);
        chk("refill_all_eaten", bus.all_eaten, 0);
        load_model();
        wait_idle();
        chk("refill_food_left", bus.food_left, fl);
    endtask

    task automatic rd(input int idx);
        bus.food_idx_y = 6'(idx);
        @(negedge clk);
        chk("row_read", bus.food_row, (idx < ROWS) ? mdl[idx] : '0);
    endtask

    task automatic set_pos(input int x, input int y);
        bus.pacman_blkpos_x = 11'(x);
        bus.pacman_blkpos_y = 10'(y);
    endtask

    // Predicts the outcome of one position update from cell arithmetic alone.
    task automatic eat(input int x, input int y);
        int  col, row;
        bit  ok;
        col = (x + 8) / 16;
        row = (y + 8) / 16;
        ok  = (col < COLS) && (row < ROWS);
        set_pos(x, y);
        bus.pos_valid = 1'b1;
        if (ok && mdl[row][col]) begin
            mdl[row][col] = 1'b0;
            sc++;
            fl--;
            q.push_back('{to_bcd(sc), fl, cyc + 1});
        end
        @(negedge clk);
        bus.pos_valid = 1'b0;
        chk("busy_after_pos", bus.busy, ok);
        repeat (2) @(negedge clk);
        chk("score_now", bus.score, to_bcd(sc));
        chk("food_left_now", bus.food_left, fl);
    endtask

    initial begin
        int n;
        bus.food_idx_y      = '0;
        bus.refill_start    = 1'b0;
        bus.pos_valid       = 1'b0;
        bus.pacman_blkpos_x = '0;
        bus.pacman_blkpos_y = '0;
        for (int r = 0; r < ROWS; r++) rom[r] = 80'h1;

        // Reset, partial refill, reset again mid-refill.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_map_addr", bus.map_addr, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_food_left", bus.food_left, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_eat_pulse", bus.eat_pulse, 0);
        chk("rst_all_eaten", bus.all_eaten, 0);
        chk("rst_food_row", bus.food_row, 0);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        chk("refill_cycles", n, 51);
        load_model();
        chk("init_food_left", bus.food_left, 50);
        chk("init_score", bus.score, 0);
        for (int i = 0; i < 64; i += 7) rd(i);
        rd(50);

        // Full map, then one eat and a repeat of the same position.
        for (int r = 0; r < ROWS; r++) rom[r] = '1;
        refill();
        chk("full_food_left", bus.food_left, 4000);
        eat(24, 40);
        rd(3);
        chk("first_eat_score", bus.score, 16'h0001);
        chk("first_eat_left", bus.food_left, 3999);
        eat(24, 40);

        // Off-map column is discarded.
        eat(1300, 40);

        // A second pos_valid while in CHECK is dropped.
        set_pos(80, 80);
        bus.pos_valid = 1'b1;
        mdl[5][5] = 1'b0;
        sc++;
        fl--;
        q.push_back('{to_bcd(sc), fl, cyc + 1});
        @(negedge clk);
        set_pos(96, 80);
        @(negedge clk);
        bus.pos_valid = 1'b0;
        repeat (2) @(negedge clk);
        rd(5);

        // refill_start aborts in CHECK, in CLEAR, and beats a same-cycle pos_valid.
        for (int k = 0; k < 3; k++) begin
            set_pos(112, 112);
            bus.pos_valid = 1'b1;
            if (k == 2) bus.refill_start = 1'b1;
            @(negedge clk);
            bus.pos_valid = 1'b0;
            if (k == 1) @(negedge clk);
            bus.refill_start = 1'b1;
            @(negedge clk);
            bus.refill_start = 1'b0;
            load_model();
            wait_idle();
            chk("abort_score", bus.score, to_bcd(sc));
            chk("abort_food_left", bus.food_left, fl);
        end

        // Random positions, including off-map ones.
        for (int i = 0; i < 200; i++)
            eat(int'($urandom_range(0, 1400)), int'($urandom_range(0, 850)));

        // Jittered full sweeps push the score through 0099->0100 and into saturation.
        for (int s = 0; s < 3; s++) begin
            refill();
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    int jx, jy;
                    jx = c * 16 + int'($urandom_range(0, 15)) - 8;
                    jy = r * 16 + int'($urandom_range(0, 15)) - 8;
                    eat((jx < 0) ? 0 : jx, (jy < 0) ? 0 : jy);
                end
            end
        end
        chk("sat_score", bus.score, 16'h9999);
        chk("sat_food_left", bus.food_left, 0);
        chk("sat_all_eaten", bus.all_eaten, 1);
        rd(0);
        rd(49);

        // Single-pellet level.
        for (int r = 0; r < ROWS; r++) rom[r] = '0;
        rom[0] = 80'h1;
        refill();
        chk("single_left", bus.food_left, 1);
        chk("single_all_eaten", bus.all_eaten, 0);
        eat(0, 0);
        chk("cleared_all_eaten", bus.all_eaten, 1);
        bus.refill_start = 1'b1;
        @(negedge clk);
        bus.refill_start = 1'b0;
        chk("refill_clears_all_eaten", bus.all_eaten, 0);
        load_model();
        wait_idle();
        chk("final_score", bus.score, 16'h9999);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
